otter_fetch_queue: RTL

//  Instruction-fetch front end for the pipelined OTTER. It owns the fetch PC and

---
 rtl/otter_fetch_queue_if.sv | 30 +++
 rtl/otter_fetch_queue.sv | 91 +++++++++
 2 files changed

// File: rtl/otter_fetch_queue_if.sv
// Bundle between the OTTER fetch queue, instruction memory port 1, execute redirect
// and decode. master = fetch queue side, slave = environment side.
`timescale 1ns/1ps
interface otter_fetch_queue_if #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 14
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic              imem_rden;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_rdata;
  logic              redirect_valid;
  logic [31:0]       redirect_pc;
  logic              de_valid;
  logic              de_ready;
  logic [31:0]       de_instr;
  logic [31:0]       de_pc;
  logic [CW-1:0]     fq_count;

  modport master (
    output imem_rden, imem_addr, de_valid, de_instr, de_pc, fq_count,
    input  imem_rdata, redirect_valid, redirect_pc, de_ready
  );

  modport slave (
    input  imem_rden, imem_addr, de_valid, de_instr, de_pc, fq_count,
    output imem_rdata, redirect_valid, redirect_pc, de_ready
  );
endinterface

// File: rtl/otter_fetch_queue.sv
// OTTER instruction-fetch front end: owns the fetch PC, issues reads to imem port 1
// and buffers returned words in a prefetch FIFO feeding decode; redirects flush it.
`timescale 1ns/1ps
module otter_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter int          ADDR_W   = 14,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst,
  otter_fetch_queue_if.master bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [31:0]   fetch_pc_reg;
  logic [31:0]   inflight_pc_reg;
  logic          inflight_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [PW-1:0] wr_ptr_reg;
  logic [CW-1:0] count_reg;
  logic [31:0]   fifo_pc_reg    [DEPTH];
  logic [31:0]   fifo_instr_reg [DEPTH];

  logic [CW-1:0] occupancy;
  logic          issue;
  logic          push;
  logic          pop;
  logic          head_valid;

  // Credit counts words already buffered plus the one still in flight, so a
  // returning word always has a free slot; a same-cycle pop is not credited.
  assign occupancy  = count_reg + CW'(inflight_reg);
  assign issue      = !bus.redirect_valid && (occupancy < FULL);
  assign push       = inflight_reg && !bus.redirect_valid;
  assign head_valid = (count_reg != '0);
  assign pop        = head_valid && bus.de_ready && !bus.redirect_valid;

  assign bus.imem_rden = issue && !rst;
  assign bus.imem_addr = fetch_pc_reg[ADDR_W+1:2];
  assign bus.de_valid  = head_valid;
  assign bus.de_instr  = head_valid ? fifo_instr_reg[rd_ptr_reg] : '0;
  assign bus.de_pc     = head_valid ? fifo_pc_reg[rd_ptr_reg]    : '0;
  assign bus.fq_count  = count_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_reg    <= RESET_PC;
      inflight_pc_reg <= '0;
      inflight_reg    <= 1'b0;
      rd_ptr_reg      <= '0;
      wr_ptr_reg      <= '0;
      count_reg       <= '0;
    end else if (bus.redirect_valid) begin
      // Any word returning this cycle belongs to the old path and is dropped.
      fetch_pc_reg <= bus.redirect_pc & ~32'h0000_0003;
      inflight_reg <= 1'b0;
      rd_ptr_reg   <= '0;
      wr_ptr_reg   <= '0;
      count_reg    <= '0;
    end else begin
      inflight_reg <= issue;
      if (issue) begin
        inflight_pc_reg <= fetch_pc_reg;
        fetch_pc_reg    <= fetch_pc_reg + 32'd4;
      end
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Storage has no reset: an entry is only observable once count covers it.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    always_ff @(posedge clk) begin
      if (push && (wr_ptr_reg == PW'(gi))) begin
        fifo_pc_reg[gi]    <= inflight_pc_reg;
        fifo_instr_reg[gi] <= bus.imem_rdata;
      end
    end
  end

  a_no_push_when_full: assert property (@(posedge clk) disable iff (rst)
    !(push && (count_reg == FULL)));

endmodule
